light_countdown_display: RTL
============================

# light_countdown_display

Downstream consumer of the two-road traffic-light controller. Samples its six lamp outputs, tracks road 0's current phase, and counts down the remaining light steps in that phase. Drives a two-digit multiplexed seven-segment display. Optionally latches a sticky fault on illegal lamp combinations. Runs on the fast system clock; the light controller advances on a slower step.

## Interface
- GREEN_STEPS, 6: light steps road 0 stays green
- YELLOW_STEPS, 2: light steps road 0 stays yellow; road 0 red lasts GREEN_STEPS+YELLOW_STEPS (must be ≤ 99)
- REFRESH_DIV, 1000: clk cycles each digit is driven before the scan switches (≥ 2)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- red_light  in  2  red lamps, bit1 = road 1, bit0 = road 0
- yellow_light  in  2  yellow lamps, same bit order
- green_light  in  2  green lamps, same bit order
- step  in  1  one-cycle pulse, clk domain, marks each light-controller state advance
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high, registered
- digit_sel  out  2  one-hot digit enable, 01 = ones, 10 = tens, registered
- fault  out  1  sticky illegal-lamp flag (0 when FAULT_DETECT_EN undefined)

## Operation
- lights = {red_light, yellow_light, green_light}. lights_q is the register of the previous sample (reset 6'b0).
- Phase of road 0 is decoded from bit0 of each lamp: green → GREEN_STEPS, yellow → YELLOW_STEPS, red → GREEN_STEPS+YELLOW_STEPS, none → load 0.
- count (7 bits, reset 0):
  - lights ≠ lights_q: load the phase duration, even if step is also high (change wins).
  - Otherwise, step high and count > 1: decrement.
  - count saturates at 1; it never wraps to 0 from a step.
- Display value: tens = count/10, ones = count%10 (combinational, compare-subtract).
  - count = 0 blanks both digits.
  - tens = 0 blanks the tens digit (leading-zero suppression).
- Scan: counter 0..REFRESH_DIV-1. On wrap, digit_sel toggles 01↔10. seg carries the pattern for the digit selected in that cycle.
- Segment patterns (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F, blank=00, dash=40.

## Timing
- Reset values: seg=7'h00, digit_sel=2'b01, fault=0, count=0, scan counter=0, lights_q=0.
- Reset mid-operation clears everything immediately. The first sample after release always differs from lights_q=0, so a valid phase reloads count.
- count updates on the same rising edge that first samples the new lights. seg/digit_sel reflect it one clk later.
- Digit period is exactly REFRESH_DIV cycles; a full frame is 2×REFRESH_DIV cycles.
- step pulses wider than one cycle decrement once per cycle high.

## Configuration
- FAULT_DETECT_EN defined:
  - fault sets when either road has zero or more than one lamp lit, or neither road is red.
  - fault is sticky until reset.
  - While fault is set, count freezes and both digits show dash (40).
  - fault asserts on the edge that samples the illegal value.
- FAULT_DETECT_EN undefined: no checker logic; fault tied 0; illegal inputs only affect the phase decode (none → count 0, blank).

## Structure
- Package traffic_display_pkg holds:
  - phase enum (PH_GREEN, PH_YELLOW, PH_RED, PH_NONE)
  - segment constants SEG_BLANK, SEG_DASH, and the digit pattern table
  - COUNT_W = 7
- One sub-module, seg7_decoder: combinational 4-bit BCD plus blank and dash controls → 7-bit pattern. The block instantiates it once on the muxed digit.

## Test plan
- Reset, then lights=6'b100001 held for 2 cycles → count=6. digit_sel toggles every REFRESH_DIV cycles; seg is 7D on ones and 00 on tens.
- Five step pulses with lights unchanged → count 6→1. A sixth step keeps count=1 (saturation).
- lights→6'b100100 with step high in the same cycle → count=2, not 1 (change wins over decrement).
- lights→6'b010010 → count=8. Set GREEN_STEPS=9, YELLOW_STEPS=3 → red count=12: tens shows 06, ones shows 5B.
- FAULT_DETECT_EN defined, drive lights=6'b000011 (both green) → fault=1 on the next edge. seg=40 on both digits; count is frozen. Restoring legal lights keeps fault=1 until reset.
- Assert reset mid-countdown at count=4 → seg=00, digit_sel=01, fault=0 immediately. Release with lights=6'b100001 → count=6.

Source files
------------

// File: rtl/traffic_display_pkg.sv
// Shared types and constants for the light countdown display: phase encoding,
// seven-segment patterns (active-high gfedcba) and binary-to-BCD conversion.
package traffic_display_pkg;

  localparam int COUNT_W = 7;

  typedef enum logic [1:0] {
    PH_GREEN,
    PH_YELLOW,
    PH_RED,
    PH_NONE
  } phase_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Index 0 is the least significant element, so the list runs 9 down to 0.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic phase_t decode_phase(input logic red0, input logic yellow0,
                                          input logic green0);
    phase_t ph;
    if (green0)       ph = PH_GREEN;
    else if (yellow0) ph = PH_YELLOW;
    else if (red0)    ph = PH_RED;
    else              ph = PH_NONE;
    return ph;
  endfunction

  // Compare-subtract split of a value 0..99 into {tens, ones}.
  function automatic logic [7:0] bin_to_bcd(input logic [COUNT_W-1:0] value);
    logic [COUNT_W-1:0] rem;
    logic [3:0]         tens;
    rem  = value;
    tens = 4'd0;
    for (int i = 9; i >= 1; i--) begin
      if (tens == 4'd0 && rem >= COUNT_W'(10 * i)) begin
        tens = 4'(i);
        rem  = rem - COUNT_W'(10 * i);
      end
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/light_countdown_display_seg7_decoder.sv
// Combinational BCD to seven-segment decoder; dash overrides blank, blank
// overrides the digit, and out-of-range codes show blank.
module seg7_decoder
  import traffic_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash)
      seg = SEG_DASH;
    else if (!blank && bcd <= 4'd9)
      seg = SEG_DIGITS[bcd];
  end

endmodule

// File: rtl/light_countdown_display.sv
// Tracks road 0's lamp phase, counts down remaining light steps and scans the
// count onto a two-digit seven-segment display. Define FAULT_DETECT_EN to add
// the sticky illegal-lamp checker.
module light_countdown_display
  import traffic_display_pkg::*;
#(
  parameter int GREEN_STEPS  = 6,
  parameter int YELLOW_STEPS = 2,
  parameter int REFRESH_DIV  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] red_light,
  input  logic [1:0] yellow_light,
  input  logic [1:0] green_light,
  input  logic       step,
  output logic [6:0] seg,
  output logic [1:0] digit_sel,
  output logic       fault
);

  localparam int SCAN_W = $clog2(REFRESH_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

  logic [5:0]         lights;
  logic [5:0]         lights_q;
  phase_t             phase;
  logic [COUNT_W-1:0] load_value;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic [SCAN_W-1:0]  scan_reg, scan_next;
  logic [1:0]         digit_sel_reg, digit_sel_next;
  logic [6:0]         seg_reg, seg_next;
  logic               fault_reg;
  logic               freeze;
  logic [7:0]         bcd;
  logic [3:0]         digit_bcd;
  logic               digit_blank;

  assign lights = {red_light, yellow_light, green_light};
  assign phase  = decode_phase(red_light[0], yellow_light[0], green_light[0]);

  always_comb begin
    load_value = '0;
    case (phase)
      PH_GREEN:  load_value = COUNT_W'(GREEN_STEPS);
      PH_YELLOW: load_value = COUNT_W'(YELLOW_STEPS);
      PH_RED:    load_value = COUNT_W'(GREEN_STEPS + YELLOW_STEPS);
      default:   load_value = '0;
    endcase
  end

`ifdef FAULT_DETECT_EN
  logic [1:0] road_bad;
  logic       illegal;

  for (genvar gi = 0; gi < 2; gi++) begin : g_road
    logic [1:0] lit_cnt;
    assign lit_cnt      = 2'(red_light[gi]) + 2'(yellow_light[gi]) + 2'(green_light[gi]);
    assign road_bad[gi] = (lit_cnt != 2'd1);
  end

  assign illegal = (|road_bad) || (red_light == 2'b00);
  // The sampling edge of an illegal value already freezes the count.
  assign freeze  = fault_reg | illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_reg <= 1'b0;
    else        fault_reg <= fault_reg | illegal;
  end
`else
  assign fault_reg = 1'b0;
  assign freeze    = 1'b0;
`endif

  // A lamp change reloads even when step is high in the same cycle.
  always_comb begin
    count_next = count_reg;
    if (!freeze) begin
      if (lights != lights_q)
        count_next = load_value;
      else if (step && count_reg > COUNT_W'(1))
        count_next = count_reg - COUNT_W'(1);
    end
  end

  always_comb begin
    scan_next      = scan_reg + SCAN_W'(1);
    digit_sel_next = digit_sel_reg;
    if (scan_reg == SCAN_LAST) begin
      scan_next      = '0;
      digit_sel_next = ~digit_sel_reg;
    end
  end

  // Segments are computed for the digit being enabled on the same edge.
  assign bcd         = bin_to_bcd(count_reg);
  assign digit_bcd   = digit_sel_next[1] ? bcd[7:4] : bcd[3:0];
  assign digit_blank = (count_reg == '0) || (digit_sel_next[1] && bcd[7:4] == 4'd0);

  seg7_decoder u_seg7_decoder (
    .bcd   (digit_bcd),
    .blank (digit_blank),
    .dash  (fault_reg),
    .seg   (seg_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lights_q      <= 6'b0;
      count_reg     <= '0;
      scan_reg      <= '0;
      digit_sel_reg <= 2'b01;
      seg_reg       <= SEG_BLANK;
    end else begin
      lights_q      <= lights;
      count_reg     <= count_next;
      scan_reg      <= scan_next;
      digit_sel_reg <= digit_sel_next;
      seg_reg       <= seg_next;
    end
  end

  assign seg       = seg_reg;
  assign digit_sel = digit_sel_reg;
  assign fault     = fault_reg;

endmodule
